// File: rtl/tls_pkg.sv
// Shared definitions for the crossroad sequencer.
// Holds the phase codes, the default phase durations in half-second ticks
// and the active-low lamp levels.
package tls_pkg;

  // Phase codes as they appear on the debug phase output.
  typedef enum logic [3:0] {
    PhAr1 = 4'd0,
    PhMg  = 4'd1,
    PhMb  = 4'd2,
    PhMy  = 4'd3,
    PhAr2 = 4'd4,
    PhSg  = 4'd5,
    PhSb  = 4'd6,
    PhSy  = 4'd7,
    PhNt  = 4'd8
  } phase_e;

  // Default durations, in ticks.
  localparam int unsigned DEF_MAIN_GREEN_T = 52;
  localparam int unsigned DEF_MAIN_MIN_T   = 20;
  localparam int unsigned DEF_SIDE_GREEN_T = 30;
  localparam int unsigned DEF_BLNK_T       = 8;
  localparam int unsigned DEF_YELLOW_T     = 6;
  localparam int unsigned DEF_ALL_RED_T    = 4;

  // Board LEDs are wired active-low.
  localparam logic LAMP_ON  = 1'b0;
  localparam logic LAMP_OFF = 1'b1;

endpackage

// File: rtl/lamp_decode.sv
// Lamp decoder for the crossroad sequencer.
// Turns the next phase and the next timer LSB into the seven active-low lamp
// drives and registers them, so the lamps change on the same edge as the phase.
// Ports:
//   time_signal  half-second tick clock
//   reset        asynchronous, active-low reset
//   phase_nxt    phase that takes effect on the coming edge
//   blink_nxt    timer[0] that takes effect on the coming edge (0 = blink lamp lit)
//   main_*/side_*  head lamps, active-low
//   ped_walk     walk lamp, active-low
module lamp_decode
  import tls_pkg::*;
(
  input  logic   time_signal,
  input  logic   reset,
  input  phase_e phase_nxt,
  input  logic   blink_nxt,
  output logic   main_red,
  output logic   main_yellow,
  output logic   main_green,
  output logic   side_red,
  output logic   side_yellow,
  output logic   side_green,
  output logic   ped_walk
);

  logic main_red_d, main_yellow_d, main_green_d;
  logic side_red_d, side_yellow_d, side_green_d;
  logic ped_walk_d;
  logic blink_lit;

  assign blink_lit = (blink_nxt == 1'b0);

  always_comb begin
    main_red_d    = LAMP_OFF;
    main_yellow_d = LAMP_OFF;
    main_green_d  = LAMP_OFF;
    side_red_d    = LAMP_OFF;
    side_yellow_d = LAMP_OFF;
    side_green_d  = LAMP_OFF;
    ped_walk_d    = LAMP_OFF;
    case (phase_nxt)
      PhMg: begin
        main_green_d = LAMP_ON;
        side_red_d   = LAMP_ON;
      end
      PhMb: begin
        main_green_d = blink_lit ? LAMP_ON : LAMP_OFF;
        side_red_d   = LAMP_ON;
      end
      PhMy: begin
        main_yellow_d = LAMP_ON;
        side_red_d    = LAMP_ON;
      end
      PhSg: begin
        main_red_d   = LAMP_ON;
        side_green_d = LAMP_ON;
        ped_walk_d   = LAMP_ON;
      end
      PhSb: begin
        main_red_d   = LAMP_ON;
        side_green_d = blink_lit ? LAMP_ON : LAMP_OFF;
      end
      PhSy: begin
        main_red_d    = LAMP_ON;
        side_yellow_d = LAMP_ON;
      end
      PhNt: begin
        main_yellow_d = blink_lit ? LAMP_ON : LAMP_OFF;
        side_yellow_d = blink_lit ? LAMP_ON : LAMP_OFF;
      end
      // All-red phases and any stray code show both reds.
      default: begin
        main_red_d = LAMP_ON;
        side_red_d = LAMP_ON;
      end
    endcase
  end

  always_ff @(posedge time_signal or negedge reset) begin
    if (!reset) begin
      main_red    <= LAMP_ON;
      main_yellow <= LAMP_OFF;
      main_green  <= LAMP_OFF;
      side_red    <= LAMP_ON;
      side_yellow <= LAMP_OFF;
      side_green  <= LAMP_OFF;
      ped_walk    <= LAMP_OFF;
    end else begin
      main_red    <= main_red_d;
      main_yellow <= main_yellow_d;
      main_green  <= main_green_d;
      side_red    <= side_red_d;
      side_yellow <= side_yellow_d;
      side_green  <= side_green_d;
      ped_walk    <= ped_walk_d;
    end
  end

  // A lit green always faces a red on the other head, and both greens are never lit together.
  a_no_double_green: assert property (@(posedge time_signal) disable iff (!reset)
    !(main_green == LAMP_ON && side_green == LAMP_ON));
  a_main_green_side_red: assert property (@(posedge time_signal) disable iff (!reset)
    (main_green == LAMP_ON) |-> (side_red == LAMP_ON));
  a_side_green_main_red: assert property (@(posedge time_signal) disable iff (!reset)
    (side_green == LAMP_ON) |-> (main_red == LAMP_ON));

endmodule

// File: rtl/crossroad_sequencer.sv
// Two-head crossroad sequencer with pedestrian walk lamp.
// Runs main green / blink / yellow, all-red, side green / blink / yellow, all-red.
// A latched pedestrian request shortens main green; night mode flashes both yellows.
// Ports:
//   time_signal  half-second tick clock
//   reset        asynchronous, active-low reset
//   ped_req      pedestrian button level, sampled each tick
//   night_mode   selects flashing-yellow operation (sampled at end of all-red)
//   main_*/side_*  head lamps, active-low
//   ped_walk     walk lamp, active-low
//   phase        current phase code, for debug
module crossroad_sequencer
  import tls_pkg::*;
#(
  parameter int unsigned MAIN_GREEN_T = DEF_MAIN_GREEN_T,
  parameter int unsigned MAIN_MIN_T   = DEF_MAIN_MIN_T,
  parameter int unsigned SIDE_GREEN_T = DEF_SIDE_GREEN_T,
  parameter int unsigned BLNK_T       = DEF_BLNK_T,
  parameter int unsigned YELLOW_T     = DEF_YELLOW_T,
  parameter int unsigned ALL_RED_T    = DEF_ALL_RED_T
) (
  input  logic       time_signal,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic       main_red,
  output logic       main_yellow,
  output logic       main_green,
  output logic       side_red,
  output logic       side_yellow,
  output logic       side_green,
  output logic       ped_walk,
  output logic [3:0] phase
);

  // Last timer value of each phase: a phase of T ticks advances when timer == T-1.
  localparam logic [7:0] MgLast  = 8'(MAIN_GREEN_T - 1);
  localparam logic [7:0] MinLast = 8'(MAIN_MIN_T - 1);
  localparam logic [7:0] SgLast  = 8'(SIDE_GREEN_T - 1);
  localparam logic [7:0] BlLast  = 8'(BLNK_T - 1);
  localparam logic [7:0] YlLast  = 8'(YELLOW_T - 1);
  localparam logic [7:0] ArLast  = 8'(ALL_RED_T - 1);

  phase_e     phase_q, phase_d;
  logic [7:0] timer_q, timer_d;
  logic       ped_pending_q, ped_pending_d;
  logic       advance;
  logic       ped_any;

  // A request on the current tick counts as already latched.
  assign ped_any = ped_pending_q | ped_req;

  always_comb begin
    phase_d = phase_q;
    advance = 1'b0;
    case (phase_q)
      PhAr1: if (timer_q == ArLast) begin
        advance = 1'b1;
        phase_d = night_mode ? PhNt : PhMg;
      end
      PhMg: if (timer_q == MgLast || (ped_any && timer_q >= MinLast)) begin
        advance = 1'b1;
        phase_d = PhMb;
      end
      PhMb: if (timer_q == BlLast) begin
        advance = 1'b1;
        phase_d = PhMy;
      end
      PhMy: if (timer_q == YlLast) begin
        advance = 1'b1;
        phase_d = PhAr2;
      end
      PhAr2: if (timer_q == ArLast) begin
        advance = 1'b1;
        phase_d = night_mode ? PhNt : PhSg;
      end
      PhSg: if (timer_q == SgLast) begin
        advance = 1'b1;
        phase_d = PhSb;
      end
      PhSb: if (timer_q == BlLast) begin
        advance = 1'b1;
        phase_d = PhSy;
      end
      PhSy: if (timer_q == YlLast) begin
        advance = 1'b1;
        phase_d = PhAr1;
      end
      // Leave night only at the end of a dark half so the yellows never get a short flash.
      PhNt: if (!night_mode && timer_q[0]) begin
        advance = 1'b1;
        phase_d = PhAr1;
      end
      default: begin
        advance = 1'b1;
        phase_d = PhAr1;
      end
    endcase

    timer_d = advance ? 8'd0 : timer_q + 8'd1;

    // Entering side green serves the pedestrian; later requests wait for the next cycle.
    if (advance && phase_d == PhSg) begin
      ped_pending_d = 1'b0;
    end else begin
      ped_pending_d = ped_any;
    end
  end

  always_ff @(posedge time_signal or negedge reset) begin
    if (!reset) begin
      phase_q       <= PhAr1;
      timer_q       <= 8'd0;
      ped_pending_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  assign phase = phase_q;

  lamp_decode u_lamp_decode (
    .time_signal (time_signal),
    .reset       (reset),
    .phase_nxt   (phase_d),
    .blink_nxt   (timer_d[0]),
    .main_red    (main_red),
    .main_yellow (main_yellow),
    .main_green  (main_green),
    .side_red    (side_red),
    .side_yellow (side_yellow),
    .side_green  (side_green),
    .ped_walk    (ped_walk)
  );

endmodule

// File: tb/tb_crossroad_sequencer.sv
// Self-checking bench for crossroad_sequencer: a phase/duration model checked every
// tick, plus hand-computed tick numbers for the directed scenarios.
module tb_crossroad_sequencer;

  logic       time_signal = 1'b0;
  logic       reset       = 1'b1;
  logic       ped_req     = 1'b0;
  logic       night_mode  = 1'b0;
  logic       main_red, main_yellow, main_green;
  logic       side_red, side_yellow, side_green;
  logic       ped_walk;
  logic [3:0] phase;

  int checks   = 0;
  int failures = 0;
  int tick_no  = 0;

  // Model: phase index, ticks already spent in the phase, latched request.
  int m_ph   = 0;
  int m_cnt  = 0;
  bit m_pend = 1'b0;

  crossroad_sequencer dut (
    .time_signal (time_signal),
    .reset       (reset),
    .ped_req     (ped_req),
    .night_mode  (night_mode),
    .main_red    (main_red),
    .main_yellow (main_yellow),
    .main_green  (main_green),
    .side_red    (side_red),
    .side_yellow (side_yellow),
    .side_green  (side_green),
    .ped_walk    (ped_walk),
    .phase       (phase)
  );

  always #5 time_signal = ~time_signal;

  initial begin
    #100000;
    $display("FAIL timeout tick=%0d actual=running required=finished", tick_no);
    $fatal(1, "bench timeout");
  end

  function automatic int dur_of(input int ph);
    case (ph)
      0, 4:    return 4;
      1:       return 52;
      2, 6:    return 8;
      3, 7:    return 6;
      5:       return 30;
      default: return 1;
    endcase
  endfunction

  // Lit lamps per phase as {mr,my,mg,sr,sy,sg,walk}, returned active-low.
  function automatic logic [6:0] exp_lamps(input int ph, input int cnt);
    logic [6:0] on;
    bit         even;
    even = (cnt % 2) == 0;
    case (ph)
      1:       on = 7'b0011000;
      2:       on = even ? 7'b0011000 : 7'b0001000;
      3:       on = 7'b0101000;
      5:       on = 7'b1000011;
      6:       on = even ? 7'b1000010 : 7'b1000000;
      7:       on = 7'b1000100;
      8:       on = even ? 7'b0100100 : 7'b0000000;
      default: on = 7'b1001000;
    endcase
    return ~on;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s tick=%0d actual=%0h required=%0h", name, tick_no, act, exp);
    end
  endtask

  task automatic model_step();
    bit leave;
    int nxt;
    if (!reset) begin
      m_ph = 0; m_cnt = 0; m_pend = 1'b0;
      return;
    end
    case (m_ph)
      8: begin
        leave = !night_mode && (m_cnt % 2 == 1);
        nxt   = 0;
      end
      1: begin
        leave = (m_cnt == 51) || ((m_pend || ped_req) && m_cnt >= 19);
        nxt   = 2;
      end
      default: begin
        leave = (m_cnt == dur_of(m_ph) - 1);
        nxt   = (m_ph + 1) % 8;
        if ((m_ph == 0 || m_ph == 4) && night_mode) nxt = 8;
      end
    endcase
    m_pend = (leave && nxt == 5) ? 1'b0 : (m_pend | ped_req);
    if (leave) begin
      m_ph  = nxt;
      m_cnt = 0;
    end else begin
      m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  task automatic compare();
    chk("lamps", {25'd0, main_red, main_yellow, main_green, side_red, side_yellow,
                  side_green, ped_walk}, {25'd0, exp_lamps(m_ph, m_cnt)});
    chk("phase", {28'd0, phase}, m_ph);
    chk("both_green", {31'd0, main_green == 1'b0 && side_green == 1'b0}, 0);
    chk("green_vs_red", {31'd0, (main_green == 1'b0 && side_red != 1'b0) ||
                                (side_green == 1'b0 && main_red != 1'b0)}, 0);
  endtask

  task automatic tick();
    @(posedge time_signal);
    model_step();
    #1;
    tick_no++;
    compare();
  endtask

  task automatic run_to(input int n);
    while (tick_no < n) tick();
  endtask

  // Asynchronous reset away from any edge, checked before the next edge arrives.
  task automatic do_reset();
    ped_req    = 1'b0;
    night_mode = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_main_red",    main_red,    0);
    chk("rst_main_yellow", main_yellow, 1);
    chk("rst_main_green",  main_green,  1);
    chk("rst_side_red",    side_red,    0);
    chk("rst_side_yellow", side_yellow, 1);
    chk("rst_side_green",  side_green,  1);
    chk("rst_ped_walk",    ped_walk,    1);
    chk("rst_phase",       phase,       0);
    m_ph = 0; m_cnt = 0; m_pend = 1'b0;
    repeat (2) tick();
    @(negedge time_signal);
    reset   = 1'b1;
    tick_no = 0;
  endtask

  initial begin
    // Normal cycle.
    do_reset();
    run_to(3);   chk("a_ar1_at_3", phase, 0);
    run_to(4);   chk("a_mg_at_4", phase, 1);   chk("a_mg_lit", main_green, 0);
    run_to(63);  chk("a_mb_at_63", phase, 2);
    run_to(64);  chk("a_my_at_64", phase, 3);  chk("a_my_lit", main_yellow, 0);
    run_to(74);  chk("a_sg_at_74", phase, 5);  chk("a_sg_lit", side_green, 0);
    run_to(117); chk("a_sy_at_117", phase, 7);
    run_to(118); chk("a_ar1_at_118", phase, 0);

    // Pedestrian pulse in MG, then a pulse during SG of the next cycle.
    do_reset();
    run_to(9);
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    run_to(23);  chk("b_mg_at_23", phase, 1);
    run_to(24);  chk("b_mb_at_24", phase, 2);
    run_to(41);  chk("b_walk_dark_41", ped_walk, 1);
    run_to(42);  chk("b_walk_lit_42", ped_walk, 0);
    run_to(71);  chk("b_walk_lit_71", ped_walk, 0);
    run_to(72);  chk("b_walk_dark_72", ped_walk, 1);
    run_to(86);  chk("b_ar1_at_86", phase, 0);
    run_to(141); chk("b_full_mg_141", phase, 1);
    run_to(164);
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    run_to(189); chk("b_sg_kept_189", phase, 5);
    run_to(190); chk("b_sb_at_190", phase, 6);
    run_to(227); chk("b_mg_at_227", phase, 1);
    run_to(228); chk("b_mb_at_228", phase, 2);

    // Night mode requested during MG.
    do_reset();
    run_to(10);
    night_mode = 1'b1;
    run_to(64);  chk("c_my_at_64", phase, 3);
    run_to(73);  chk("c_ar2_at_73", phase, 4);
    run_to(74);  chk("c_nt_at_74", phase, 8);
    chk("c_my_lit_74", main_yellow, 0);        chk("c_sy_lit_74", side_yellow, 0);
    run_to(75);  chk("c_my_dark_75", main_yellow, 1);
    chk("c_mg_dark_75", main_green, 1);
    run_to(80);  chk("c_sy_lit_80", side_yellow, 0);
    night_mode = 1'b0;
    run_to(81);  chk("c_nt_at_81", phase, 8);
    run_to(82);  chk("c_ar1_at_82", phase, 0);
    run_to(85);  chk("c_ar1_at_85", phase, 0);
    run_to(86);  chk("c_mg_at_86", phase, 1);  chk("c_mg_lit_86", main_green, 0);

    // Reset in the middle of SB, then a clean restart.
    do_reset();
    run_to(106); chk("d_sb_at_106", phase, 6);
    do_reset();
    run_to(3);   chk("d_ar1_at_3", phase, 0);
    run_to(4);   chk("d_mg_at_4", phase, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
